// File: rtl/vga_stream_gen.sv
// ---------------------------------------------------------------------------
// vga_stream_gen
//
// VGA timing generator with built-in test patterns and a streamed-pixel
// mode. The horizontal and vertical counters run front porch, sync, back
// porch, then active video. Every VGA_* output, x_out, y_out and sof is
// registered, so the outputs lag the counters by one pixel clock.
//
// Ports
//   pixel_clk      in   pixel clock
//   pixel_rst      in   asynchronous active-high reset
//   mode      [1:0] in  0=grid, 1=colour bars, 2=checker, 3=stream
//   pix_data [23:0] in  streamed RGB888 pixel
//   pix_valid      in   pix_data holds a pixel
//   pix_ready      out  pixel consumed this cycle (combinational)
//   underflow_clr  in   clears the sticky underflow flag
//   VGA_CLK        out  copy of pixel_clk
//   VGA_HS/VGA_VS  out  horizontal/vertical sync (level set by HS_POL/VS_POL)
//   VGA_BLANK      out  1 during active video
//   VGA_RGB  [23:0] out pixel colour, 0 outside active video
//   x_out / y_out  out  active column/row, held outside active video
//   sof            out  one-cycle pulse with pixel (0,0)
//   underflow      out  sticky flag: stream was starved of a pixel
// ---------------------------------------------------------------------------
module vga_stream_gen #(
   parameter int HDISP  = 800,
   parameter int VDISP  = 480,
   parameter int HFP    = 40,
   parameter int HPULSE = 48,
   parameter int HBP    = 40,
   parameter int VFP    = 13,
   parameter int VPULSE = 3,
   parameter int VBP    = 29,
   parameter int HS_POL = 0,
   parameter int VS_POL = 0,
   parameter int GRID   = 16
) (
   input  logic                       pixel_clk,
   input  logic                       pixel_rst,
   input  logic [1:0]                 mode,
   input  logic [23:0]                pix_data,
   input  logic                       pix_valid,
   output logic                       pix_ready,
   input  logic                       underflow_clr,
   output logic                       VGA_CLK,
   output logic                       VGA_HS,
   output logic                       VGA_VS,
   output logic                       VGA_BLANK,
   output logic [23:0]                VGA_RGB,
   output logic [$clog2(HDISP)-1:0]   x_out,
   output logic [$clog2(VDISP)-1:0]   y_out,
   output logic                       sof,
   output logic                       underflow
);

   localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
   localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
   localparam int HSTART = HFP + HPULSE + HBP;
   localparam int VSTART = VFP + VPULSE + VBP;
   localparam int HCW    = $clog2(HTOTAL);
   localparam int VCW    = $clog2(VTOTAL);
   localparam int XW     = $clog2(HDISP);
   localparam int YW     = $clog2(VDISP);
   // Bars are HDISP/8 wide; guard keeps the divisor legal for tiny displays.
   localparam int BAR_W  = (HDISP >= 8) ? (HDISP / 8) : 1;

   localparam logic [HCW-1:0] H_LAST   = HCW'(HTOTAL - 1);
   localparam logic [HCW-1:0] H_SYNC_B = HCW'(HFP);
   localparam logic [HCW-1:0] H_SYNC_E = HCW'(HFP + HPULSE - 1);
   localparam logic [HCW-1:0] H_ACT    = HCW'(HSTART);
   localparam logic [VCW-1:0] V_LAST   = VCW'(VTOTAL - 1);
   localparam logic [VCW-1:0] V_SYNC_B = VCW'(VFP);
   localparam logic [VCW-1:0] V_SYNC_E = VCW'(VFP + VPULSE - 1);
   localparam logic [VCW-1:0] V_ACT    = VCW'(VSTART);

   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   localparam logic [1:0] MODE_STREAM = 2'd3;

   // Test-pattern colour for an active pixel (modes 0-2).
   function automatic logic [23:0] pattern_rgb(input logic [1:0] m,
                                               input int xi, input int yi);
      logic [23:0] rgb;
      rgb = 24'h000000;
      case (m)
         2'd0: begin
            if (((xi % GRID) == GRID - 1) || ((yi % GRID) == GRID - 1))
               rgb = 24'hFFFFFF;
         end
         2'd1: begin
            case (xi / BAR_W)
               0:       rgb = 24'hFFFFFF;
               1:       rgb = 24'hFFFF00;
               2:       rgb = 24'h00FFFF;
               3:       rgb = 24'h00FF00;
               4:       rgb = 24'hFF00FF;
               5:       rgb = 24'hFF0000;
               6:       rgb = 24'h0000FF;
               default: rgb = 24'h000000;  // bar 7 and the leftover columns
            endcase
         end
         2'd2: begin
            if ((((xi / GRID) + (yi / GRID)) % 2) == 1)
               rgb = 24'hFFFFFF;
         end
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

   logic [HCW-1:0] hcnt_q, hcnt_d;
   logic [VCW-1:0] vcnt_q, vcnt_d;
   logic [1:0]     mode_q, mode_d;
   logic           hs_q, hs_d;
   logic           vs_q, vs_d;
   logic           blank_q, blank_d;
   logic [23:0]    rgb_q, rgb_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic           sof_q, sof_d;
   logic           uf_q, uf_d;

   logic           active_c;
   logic [XW-1:0]  x_c;
   logic [YW-1:0]  y_c;

   assign active_c  = (hcnt_q >= H_ACT) && (vcnt_q >= V_ACT);
   assign x_c       = XW'(hcnt_q - H_ACT);
   assign y_c       = YW'(vcnt_q - V_ACT);
   // Mode is only read through the register, so ready drops to 0 while reset
   // holds the counters at the origin (outside the active region).
   assign pix_ready = active_c && (mode_q == MODE_STREAM);

   always_comb begin
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      mode_d  = mode_q;
      hs_d    = ~HS_ON;
      vs_d    = ~VS_ON;
      blank_d = active_c;
      rgb_d   = 24'h000000;
      x_d     = x_q;
      y_d     = y_q;
      sof_d   = 1'b0;
      uf_d    = uf_q;

      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCW'(1);
      end else begin
         hcnt_d = hcnt_q + HCW'(1);
      end

      // Mode changes land only at the frame origin, so a frame never mixes patterns.
      if ((hcnt_q == '0) && (vcnt_q == '0))
         mode_d = mode;

      if ((hcnt_q >= H_SYNC_B) && (hcnt_q <= H_SYNC_E))
         hs_d = HS_ON;
      if ((vcnt_q >= V_SYNC_B) && (vcnt_q <= V_SYNC_E))
         vs_d = VS_ON;

      if (active_c) begin
         x_d   = x_c;
         y_d   = y_c;
         sof_d = (x_c == '0) && (y_c == '0);
         if (mode_q == MODE_STREAM)
            rgb_d = pix_valid ? pix_data : 24'h000000;
         else
            rgb_d = pattern_rgb(mode_q, int'(x_c), int'(y_c));
      end

      // A starved pixel is shown black and the timing keeps running; a new
      // starvation event outranks a simultaneous clear.
      if (pix_ready && !pix_valid)
         uf_d = 1'b1;
      else if (underflow_clr)
         uf_d = 1'b0;
   end

   // Counter / output register stage
   always_ff @(posedge pixel_clk or posedge pixel_rst) begin
      if (pixel_rst) begin
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         mode_q  <= 2'd0;
         hs_q    <= ~HS_ON;
         vs_q    <= ~VS_ON;
         blank_q <= 1'b0;
         rgb_q   <= 24'h000000;
         x_q     <= '0;
         y_q     <= '0;
         sof_q   <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         mode_q  <= mode_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         rgb_q   <= rgb_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sof_q   <= sof_d;
         uf_q    <= uf_d;
      end
   end

   assign VGA_CLK   = pixel_clk;
   assign VGA_HS    = hs_q;
   assign VGA_VS    = vs_q;
   assign VGA_BLANK = blank_q;
   assign VGA_RGB   = rgb_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign sof       = sof_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_vga_stream_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_stream_gen
//
// Bench for vga_stream_gen using a scaled-down display so several whole
// frames fit in a short run. A behavioural model derives the expected
// outputs from the elapsed cycle count since reset release; a set of literal
// expectations (sync timing, pattern pixels, stream values) pins the model.
// ---------------------------------------------------------------------------
module tb_vga_stream_gen;

   localparam int HDISP = 36, VDISP = 24;
   localparam int HFP = 4, HPULSE = 5, HBP = 3;
   localparam int VFP = 2, VPULSE = 2, VBP = 3;
   localparam int GRID = 4;
   localparam int HT = HFP + HPULSE + HBP + HDISP;   // 48
   localparam int VT = VFP + VPULSE + VBP + VDISP;   // 31
   localparam int HA = HFP + HPULSE + HBP;           // 12
   localparam int VA = VFP + VPULSE + VBP;           // 7
   localparam int F  = HT * VT;                      // 1488
   localparam int BW = HDISP / 8;                    // 4

   localparam int S_SW1      = 2*F + (VA+10)*HT + 20;   // grid -> bars at y=10
   localparam int S_GRID_PIN = 2*F + (VA+14)*HT + HA + 5;
   localparam int S_BAR_PIN  = 3*F + (VA+14)*HT + HA + 5;
   localparam int S_SW2      = 4*F + 100;               // -> checker
   localparam int S_SW3      = 5*F + 100;               // -> stream
   localparam int S_STR_FST  = 6*F + VA*HT + HA;
   localparam int S_STR_LST  = 7*F - 1;
   localparam int S_DROP     = 7*F + (VA+5)*HT + HA + 7;
   localparam int S_CLR      = S_DROP + 200;
   localparam int S_BOTH     = S_DROP + 400;
   localparam int S_SW4      = 7*F + 1100;              // -> bars
   localparam int S_RST      = 8*F + (VA+3)*HT + 17;

   localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
      24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   logic        pixel_clk, pixel_rst;
   logic [1:0]  mode;
   logic [23:0] pix_data;
   logic        pix_valid, pix_ready, underflow_clr;
   logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK;
   logic [23:0] VGA_RGB;
   logic [5:0]  x_out;
   logic [4:0]  y_out;
   logic        sof, underflow;

   vga_stream_gen #(
      .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
      .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(0), .VS_POL(0), .GRID(GRID)
   ) dut (
      .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .underflow_clr(underflow_clr), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
      .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_RGB(VGA_RGB),
      .x_out(x_out), .y_out(y_out), .sof(sof), .underflow(underflow)
   );

   initial begin
      pixel_clk = 1'b0;
      forever #5 pixel_clk = ~pixel_clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_hs"},    32'(VGA_HS),    32'd1);
      check({tag, "_vs"},    32'(VGA_VS),    32'd1);
      check({tag, "_blank"}, 32'(VGA_BLANK), 32'd0);
      check({tag, "_rgb"},   32'(VGA_RGB),   32'd0);
      check({tag, "_x"},     32'(x_out),     32'd0);
      check({tag, "_y"},     32'(y_out),     32'd0);
      check({tag, "_sof"},   32'(sof),       32'd0);
      check({tag, "_uf"},    32'(underflow), 32'd0);
      check({tag, "_ready"}, 32'(pix_ready), 32'd0);
   endtask

   function automatic logic [23:0] model_pix(input int m, input int x, input int y,
                                             input logic v, input logic [23:0] d);
      if (m == 0) return ((x % GRID == GRID-1) || (y % GRID == GRID-1)) ? 24'hFFFFFF : 24'h0;
      if (m == 1) return (x / BW < 8) ? BAR_TAB[x / BW] : 24'h0;
      if (m == 2) return ((((x / GRID) + (y / GRID)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      return v ? d : 24'h0;
   endfunction

   // ---------------- model + compare (sampled on the falling edge) --------
   bit          started = 0;
   int          k, s, h, v, lx, ly, mode_m, m_used;
   bit          act, uf_m, prev_hs;
   int          last_fall, last_sof;
   int          hs_low, vs_low, blank_cnt, sof_cnt, xfer_cnt;
   logic [1:0]  p_mode;
   logic [23:0] p_data, e_rgb;
   logic        p_valid, p_clr, e_hs, e_vs, e_sof;

   always @(negedge pixel_clk) begin
      if (pixel_rst) begin
         started = 0; mode_m = 0; uf_m = 0; lx = 0; ly = 0;
         last_fall = -1; last_sof = -1; prev_hs = 1'b1;
         hs_low = 0; vs_low = 0; blank_cnt = 0; sof_cnt = 0; xfer_cnt = 0;
      end else begin
         if (!started) begin
            started = 1;
            k = 0;
            check_idle("release");
         end else begin
            k++;
            s = k - 1;                       // counter state now on the outputs
            h = s % HT;
            v = (s / HT) % VT;
            act = (h >= HA) && (v >= VA);
            if (act) begin
               lx = h - HA;
               ly = v - VA;
            end
            e_hs  = (h >= HFP && h < HFP + HPULSE) ? 1'b0 : 1'b1;
            e_vs  = (v >= VFP && v < VFP + VPULSE) ? 1'b0 : 1'b1;
            m_used = mode_m;
            e_rgb = act ? model_pix(m_used, lx, ly, p_valid, p_data) : 24'h0;
            e_sof = act && (lx == 0) && (ly == 0);
            if (act && (m_used == 3) && !p_valid) uf_m = 1'b1;
            else if (p_clr)                       uf_m = 1'b0;
            if (h == 0 && v == 0) mode_m = int'(p_mode);

            check("hs",    32'(VGA_HS),    32'(e_hs));
            check("vs",    32'(VGA_VS),    32'(e_vs));
            check("blank", 32'(VGA_BLANK), 32'(act));
            check("rgb",   32'(VGA_RGB),   32'(e_rgb));
            check("x_out", 32'(x_out),     32'(lx));
            check("y_out", 32'(y_out),     32'(ly));
            check("sof",   32'(sof),       32'(e_sof));
            check("uf",    32'(underflow), 32'(uf_m));

            // literal pins
            if (k == 4) check("hs_before_first_sync", 32'(VGA_HS), 32'd1);
            if (k == 5) check("hs_first_sync",        32'(VGA_HS), 32'd0);
            if (act && m_used == 0 && ly == 0 && lx == 2) check("grid_y0_x2", 32'(VGA_RGB), 32'h000000);
            if (act && m_used == 0 && ly == 0 && lx == 3) check("grid_y0_x3", 32'(VGA_RGB), 32'hFFFFFF);
            if (act && m_used == 0 && ly == 3)            check("grid_row3",  32'(VGA_RGB), 32'hFFFFFF);
            if (act && m_used == 1 && lx == 0)  check("bar_x0",  32'(VGA_RGB), 32'hFFFFFF);
            if (act && m_used == 1 && lx == 4)  check("bar_x4",  32'(VGA_RGB), 32'hFFFF00);
            if (act && m_used == 1 && lx == 27) check("bar_x27", 32'(VGA_RGB), 32'h0000FF);
            if (act && m_used == 1 && lx == 35) check("bar_x35", 32'(VGA_RGB), 32'h000000);
            if (s == S_GRID_PIN) check("grid_rest_of_frame", 32'(VGA_RGB), 32'h000000);
            if (s == S_BAR_PIN)  check("bars_next_frame",    32'(VGA_RGB), 32'hFFFF00);
            if (s == S_STR_FST)  check("stream_first_pixel", 32'(VGA_RGB), 32'h000100);
            if (s == S_STR_LST)  check("stream_last_pixel",  32'(VGA_RGB), 32'h00045F);
            if (s == S_STR_LST)  check("stream_no_uf",       32'(underflow), 32'd0);
            if (s == S_DROP - 1) check("uf_before_drop",     32'(underflow), 32'd0);
            if (s == S_DROP)     check("starved_pixel",      32'(VGA_RGB), 32'h000000);
            if (s == S_DROP)     check("uf_after_drop",      32'(underflow), 32'd1);
            if (s == S_CLR - 1)  check("uf_sticky",          32'(underflow), 32'd1);
            if (s == S_CLR)      check("uf_cleared",         32'(underflow), 32'd0);
            if (s == S_BOTH)     check("uf_set_wins",        32'(underflow), 32'd1);

            if (prev_hs && !VGA_HS) begin
               if (last_fall >= 0) check("hs_period", 32'(k - last_fall), 32'd48);
               last_fall = k;
            end
            prev_hs = VGA_HS;
            if (sof) begin
               if (last_sof >= 0) check("frame_len", 32'(k - last_sof), 32'd1488);
               last_sof = k;
            end

            if (s >= F && s < 2*F) begin
               hs_low    += (VGA_HS == 1'b0) ? 1 : 0;
               vs_low    += (VGA_VS == 1'b0) ? 1 : 0;
               blank_cnt += VGA_BLANK ? 1 : 0;
               sof_cnt   += sof ? 1 : 0;
            end
            if (s == 2*F - 1) begin
               check("hs_low_per_frame", 32'(hs_low),    32'd155);
               check("vs_low_cycles",    32'(vs_low),    32'd96);
               check("blank_per_frame",  32'(blank_cnt), 32'd864);
               check("sof_per_frame",    32'(sof_cnt),   32'd1);
            end
         end

         // pix_ready belongs to the counter state present right now
         h = k % HT;
         v = (k / HT) % VT;
         check("pix_ready", 32'(pix_ready), 32'((h >= HA) && (v >= VA) && (mode_m == 3)));
         if (k == 7*F) check("transfers_per_frame", 32'(xfer_cnt), 32'd864);
         if (k >= 6*F && k < 7*F && pix_ready && pix_valid) xfer_cnt++;

         p_mode  = mode;
         p_valid = pix_valid;
         p_data  = pix_data;
         p_clr   = underflow_clr;
      end
   end

   // ---------------- stimulus ---------------------------------------------
   int cur = 0;

   task automatic step();
      logic xfer;
      @(negedge pixel_clk);
      xfer = pix_ready && pix_valid;
      @(posedge pixel_clk);
      #1;
      if (xfer) pix_data = pix_data + 24'd1;
      cur++;
   endtask

   task automatic goto_state(input int target);
      while (cur < target) step();
   endtask

   initial begin
      pixel_rst = 1'b1; mode = 2'd0; pix_data = 24'h000100;
      pix_valid = 1'b1; underflow_clr = 1'b0;
      repeat (2) @(posedge pixel_clk);
      #1;
      check_idle("reset");
      check("vga_clk_high", 32'(VGA_CLK), 32'd1);
      @(negedge pixel_clk);
      #1;
      check("vga_clk_low", 32'(VGA_CLK), 32'd0);
      @(posedge pixel_clk);
      #1;
      pixel_rst = 1'b0;
      cur = 0;

      goto_state(S_SW1);  mode = 2'd1;
      goto_state(S_SW2);  mode = 2'd2;
      goto_state(S_SW3);  mode = 2'd3;
      goto_state(S_DROP); pix_valid = 1'b0;     step(); pix_valid = 1'b1;
      goto_state(S_CLR);  underflow_clr = 1'b1; step(); underflow_clr = 1'b0;
      goto_state(S_BOTH); pix_valid = 1'b0; underflow_clr = 1'b1; step();
      pix_valid = 1'b1; underflow_clr = 1'b0;
      goto_state(S_SW4);  mode = 2'd1;

      // asynchronous reset mid-line of a bars frame
      goto_state(S_RST);
      #2;
      pixel_rst = 1'b1;
      #1;
      check_idle("async_rst");
      repeat (3) @(posedge pixel_clk);
      #1;
      check_idle("rst_hold");
      check("vga_clk_rst_high", 32'(VGA_CLK), 32'd1);
      @(negedge pixel_clk);
      #1;
      check("vga_clk_rst_low", 32'(VGA_CLK), 32'd0);
      @(posedge pixel_clk);
      #1;
      pixel_rst = 1'b0;
      cur = 0;
      goto_state(F + 60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
